// File: rtl/mul_inverse_div.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per cycle. Feeding it A*B with divisor B returns A with remainder 0.
module mul_inverse_div #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     partRem_q, partRem_d;
    logic [N-1:0]   shiftQ_q, shiftQ_d;
    logic [N-1:0]   divisorLat_q, divisorLat_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remOut_q, remOut_d;
    logic           divZero_q, divZero_d;
    logic           overflow_q, overflow_d;

    logic           accept;
    logic           divisorIsZero;
    logic           quotTooWide;
    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           qBit;

    // A start is honoured in FIN as well as IDLE so that operations can run back to back.
    assign accept        = start && ((state_q == IDLE) || (state_q == FIN));
    assign divisorIsZero = (divisor == '0);
    assign quotTooWide   = (dividend[2*N-1:N] >= divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            partRem_q    <= '0;
            shiftQ_q     <= '0;
            divisorLat_q <= '0;
            count_q      <= '0;
            quot_q       <= '0;
            remOut_q     <= '0;
            divZero_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            partRem_q    <= partRem_d;
            shiftQ_q     <= shiftQ_d;
            divisorLat_q <= divisorLat_d;
            count_q      <= count_d;
            quot_q       <= quot_d;
            remOut_q     <= remOut_d;
            divZero_q    <= divZero_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FIN: begin
                if (accept) begin
                    if (divisorIsZero || quotTooWide) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (count_q == '0) begin
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == FIN);
    end

    // Trial subtraction at N+1 bits; the top bit set means the shifted remainder was smaller.
    always_comb begin
        shifted = {partRem_q[N-1:0], shiftQ_q[N-1]};
        trial   = shifted - {1'b0, divisorLat_q};
        qBit    = ~trial[N];
    end

    always_comb begin
        partRem_d    = partRem_q;
        shiftQ_d     = shiftQ_q;
        divisorLat_d = divisorLat_q;
        count_d      = count_q;
        quot_d       = quot_q;
        remOut_d     = remOut_q;
        divZero_d    = divZero_q;
        overflow_d   = overflow_q;

        if (accept) begin
            divisorLat_d = divisor;
            if (divisorIsZero) begin
                divZero_d  = 1'b1;
                overflow_d = 1'b0;
                quot_d     = '1;
                remOut_d   = '0;
            end else if (quotTooWide) begin
                divZero_d  = 1'b0;
                overflow_d = 1'b1;
                quot_d     = '1;
                remOut_d   = '0;
            end else begin
                partRem_d = {1'b0, dividend[2*N-1:N]};
                shiftQ_d  = dividend[N-1:0];
                count_d   = CW'(N - 1);
            end
        end else if (state_q == RUN) begin
            partRem_d = qBit ? trial : shifted;
            shiftQ_d  = {shiftQ_q[N-2:0], qBit};
            if (count_q == '0) begin
                // Publish the result only on the transition into FIN.
                quot_d     = {shiftQ_q[N-2:0], qBit};
                remOut_d   = qBit ? trial[N-1:0] : shifted[N-1:0];
                divZero_d  = 1'b0;
                overflow_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    assign quotient  = quot_q;
    assign remainder = remOut_q;
    assign div_zero  = divZero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mul_inverse_div.sv
// Scoreboard bench for mul_inverse_div: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_inverse_div;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           doneEdge;
        string        name;
    } expT;

    expT sb[$];
    int  testsRun   = 0;
    int  failCount  = 0;
    int  cycleCount = 0;

    mul_inverse_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cycleCount);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expT e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "/quotient"},  32'(quotient),   32'(e.q));
                checkOutput({e.name, "/remainder"}, 32'(remainder),  32'(e.r));
                checkOutput({e.name, "/div_zero"},  32'(div_zero),   32'(e.dz));
                checkOutput({e.name, "/overflow"},  32'(overflow),   32'(e.ov));
                checkOutput({e.name, "/busyAtDone"}, 32'(busy),      32'd0);
                checkOutput({e.name, "/doneEdge"},  32'(cycleCount), 32'(e.doneEdge));
            end
        end
    end

    function automatic expT makeExp(input logic [N-1:0] q, input logic [N-1:0] r,
                                    input logic dz, input logic ov, input int edge0,
                                    input string name);
        expT e;
        e.q        = q;
        e.r        = r;
        e.dz       = dz;
        e.ov       = ov;
        e.doneEdge = edge0 + ((dz || ov) ? 1 : N + 1);
        e.name     = name;
        return e;
    endfunction

    // Called at a negedge; the preceding posedge is edge 0 of the operation.
    task automatic applyStimulus(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                                 input logic [N-1:0] expQ, input logic [N-1:0] expR,
                                 input logic dz, input logic ov, input string name);
        sb.push_back(makeExp(expQ, expR, dz, ov, cycleCount, name));
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput({name, "/timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        int r;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset/busy",      32'(busy),      32'd0);
        checkOutput("reset/done",      32'(done),      32'd0);
        checkOutput("reset/quotient",  32'(quotient),  32'd0);
        checkOutput("reset/remainder", 32'(remainder), 32'd0);
        checkOutput("reset/div_zero",  32'(div_zero),  32'd0);
        checkOutput("reset/overflow",  32'(overflow),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h7530, 8'h96, 8'hC8, 8'h00, 1'b0, 1'b0, "exact");
        checkOutput("exact/busyRun", 32'(busy), 32'd1);
        drain("exact");
        checkOutput("exact/quotientHold", 32'(quotient), 32'hC8);

        applyStimulus(16'h7531, 8'h96, 8'hC8, 8'h01, 1'b0, 1'b0, "rem1");
        drain("rem1");
        applyStimulus(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "maxProd");
        drain("maxProd");
        applyStimulus(16'h00FE, 8'hFF, 8'h00, 8'hFE, 1'b0, 1'b0, "zeroQuot");
        drain("zeroQuot");
        applyStimulus(16'hC350, 8'hC8, 8'hFA, 8'h00, 1'b0, 1'b0, "c350");
        drain("c350");
        applyStimulus(16'h1234, 8'h13, 8'hF5, 8'h05, 1'b0, 1'b0, "odd");
        drain("odd");
        applyStimulus(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, "divOne");
        drain("divOne");

        applyStimulus(16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, "divZero");
        checkOutput("divZero/busy", 32'(busy), 32'd0);
        drain("divZero");
        applyStimulus(16'h9600, 8'h96, 8'hFF, 8'h00, 1'b0, 1'b1, "overflow");
        checkOutput("overflow/busy", 32'(busy), 32'd0);
        drain("overflow");

        // Second start at edge 4 must be ignored entirely.
        applyStimulus(16'h7530, 8'h96, 8'hC8, 8'h00, 1'b0, 1'b0, "busyProt");
        repeat (2) @(negedge clk);
        dividend = 16'h0001;
        divisor  = 8'h01;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        drain("busyProt");

        // Abort mid-operation with an asynchronous reset.
        applyStimulus(16'h7531, 8'h96, 8'hC8, 8'h01, 1'b0, 1'b0, "abort");
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("abort/quotient",  32'(quotient),  32'd0);
        checkOutput("abort/remainder", 32'(remainder), 32'd0);
        checkOutput("abort/busy",      32'(busy),      32'd0);
        checkOutput("abort/done",      32'(done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h7531, 8'h96, 8'hC8, 8'h01, 1'b0, 1'b0, "afterAbort");
        drain("afterAbort");

        // start held through FIN: second operand set is sampled on leaving FIN.
        sb.push_back(makeExp(8'hC8, 8'h00, 1'b0, 1'b0, cycleCount, "b2b1"));
        sb.push_back(makeExp(8'hC8, 8'h01, 1'b0, 1'b0, cycleCount + N + 1, "b2b2"));
        dividend = 16'h7530;
        divisor  = 8'h96;
        start    = 1'b1;
        @(negedge clk);
        dividend = 16'h7531;
        repeat (N + 1) @(negedge clk);
        start    = 1'b0;
        drain("b2b");

        // Back-to-back error operations give consecutive done cycles.
        sb.push_back(makeExp(8'hFF, 8'h00, 1'b1, 1'b0, cycleCount, "errB2b1"));
        sb.push_back(makeExp(8'hFF, 8'h00, 1'b1, 1'b0, cycleCount + 1, "errB2b2"));
        dividend = 16'h1234;
        divisor  = 8'h00;
        start    = 1'b1;
        repeat (2) @(negedge clk);
        start    = 1'b0;
        drain("errB2b");

        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            r = int'($urandom_range(0, b - 1));
            applyStimulus(16'(a * b + r), 8'(b), 8'(a), 8'(r), 1'b0, 1'b0, "random");
            drain("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
